// File: rtl/linear_read_data_sink.sv
// linear_read_data_sink
//
// Receives the AXI4 R-channel beats returned for the fixed-length bursts issued by the
// linear read address generator. The first dataSizeInBeats beats are forwarded onto an
// AXI-Stream master port, and m_axis_tlast marks the final forwarded beat. Surplus beats
// from the rounded-up final burst are accepted and dropped. An rresp error or a wrongly
// placed rlast raises a sticky error flag. The start/done handshake matches the address
// generator, so one controller can launch both blocks with the same size.
//
// Ports:
//   aclk, reset            clock, asynchronous active-high reset
//   start, done            launch (sampled only while done=1) / idle-complete flag
//   dataSizeInBeats        number of beats to forward, latched on an accepted start
//   error                  sticky framing/response error, cleared by an accepted start
//   rid, rdata, rresp,
//   rlast, rvalid, rready  AXI4 read-data channel (rid is ignored)
//   m_axis_t*              AXI-Stream master output
module linear_read_data_sink #(
    parameter int unsigned DATA_WIDTH               = 64,
    parameter int unsigned ID_WIDTH                 = 8,
    parameter int unsigned SIZE_WIDTH               = 32,
    parameter int unsigned AxLEN_BEATS_PER_TRANSFER = 15
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  done,
    input  logic [SIZE_WIDTH-1:0] dataSizeInBeats,
    output logic                  error,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int unsigned BurstBeats = AxLEN_BEATS_PER_TRANSFER + 1;
    localparam int unsigned BurstCntW  = (BurstBeats > 1) ? $clog2(BurstBeats) : 1;
    // One extra bit so the rounded-up beat total never overflows.
    localparam int unsigned CntW       = SIZE_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                  state_q;
    logic [SIZE_WIDTH-1:0]   n_q;
    logic [CntW-1:0]         r_q;
    logic [BurstCntW-1:0]    burst_cnt_q;
    logic                    done_q;
    logic                    error_q;
    logic                    rready_q;

    // Two-entry skid buffer; entry 0 is the head that drives the stream port.
    logic [DATA_WIDTH-1:0]   buf_data_q [2];
    logic                    buf_last_q [2];
    logic [1:0]              count_q;
    logic [1:0]              count_d;

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic [CntW-1:0]         n_ext;
    logic [CntW-1:0]         r_inc;
    logic                    burst_end;
    logic                    beat_is_last;
    logic                    final_beat;
    logic                    frame_err;

    logic                    unused_rid;
    assign unused_rid = ^rid;

    assign n_ext        = {1'b0, n_q};
    assign r_inc        = r_q + CntW'(1);
    assign accept       = rvalid && rready_q;
    assign push         = accept && (r_q < n_ext);
    assign pop          = (count_q != 2'd0) && m_axis_tready;
    assign burst_end    = (burst_cnt_q == BurstCntW'(BurstBeats - 1));
    assign beat_is_last = (r_inc == n_ext);
    // The rounded-up total is the first burst boundary at or past N. That equals
    // ceil(N/B)*B without needing a divider.
    assign final_beat   = burst_end && (r_inc >= n_ext);
    assign frame_err    = (rlast != burst_end) || (rresp != 2'b00);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            n_q           <= '0;
            r_q           <= '0;
            burst_cnt_q   <= '0;
            done_q        <= 1'b1;
            error_q       <= 1'b0;
            rready_q      <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            // Skid buffer. A push into a full buffer cannot happen, because rready is
            // already low whenever the buffer is full.
            if (push && !pop) begin
                if (count_q == 2'd0) begin
                    buf_data_q[0] <= rdata;
                    buf_last_q[0] <= beat_is_last;
                end else begin
                    buf_data_q[1] <= rdata;
                    buf_last_q[1] <= beat_is_last;
                end
            end else if (pop && !push) begin
                buf_data_q[0] <= buf_data_q[1];
                buf_last_q[0] <= buf_last_q[1];
            end else if (push && pop) begin
                if (count_q == 2'd1) begin
                    buf_data_q[0] <= rdata;
                    buf_last_q[0] <= beat_is_last;
                end else begin
                    buf_data_q[0] <= buf_data_q[1];
                    buf_last_q[0] <= buf_last_q[1];
                    buf_data_q[1] <= rdata;
                    buf_last_q[1] <= beat_is_last;
                end
            end
            count_q <= count_d;

            unique case (state_q)
                StIdle: begin
                    rready_q <= 1'b0;
                    if (start) begin
                        n_q         <= dataSizeInBeats;
                        r_q         <= '0;
                        burst_cnt_q <= '0;
                        error_q     <= 1'b0;
                        if (dataSizeInBeats != '0) begin
                            done_q   <= 1'b0;
                            rready_q <= 1'b1;
                            state_q  <= StRun;
                        end
                    end
                end
                StRun: begin
                    rready_q <= (count_d != 2'd2);
                    if (accept) begin
                        r_q         <= r_inc;
                        burst_cnt_q <= burst_end ? '0 : burst_cnt_q + BurstCntW'(1);
                        if (frame_err) begin
                            error_q <= 1'b1;
                        end
                        if (final_beat) begin
                            rready_q <= 1'b0;
                            state_q  <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    rready_q <= 1'b0;
                    if (count_q == 2'd0) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    rready_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign done          = done_q;
    assign error         = error_q;
    assign rready        = rready_q;
    assign m_axis_tdata  = buf_data_q[0];
    assign m_axis_tlast  = buf_last_q[0];
    assign m_axis_tvalid = (count_q != 2'd0);

endmodule

// File: tb/tb_linear_read_data_sink.sv
// Testbench for linear_read_data_sink.
// The reference model works at the transfer level. It expands each transfer into
// ceil(N/B)*B source beats and expects the first N of them on the stream, in order.
// The model also predicts rready from the buffer occupancy and the done edge from the
// last accept and last pop.
module tb_linear_read_data_sink;

    localparam int B = 16;

    logic        aclk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [31:0] dataSizeInBeats;
    logic        error;
    logic [7:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    int n_checks = 0;
    int n_pass   = 0;

    linear_read_data_sink dut (
        .aclk            (aclk),
        .reset           (reset),
        .start           (start),
        .done            (done),
        .dataSizeInBeats (dataSizeInBeats),
        .error           (error),
        .rid             (rid),
        .rdata           (rdata),
        .rresp           (rresp),
        .rlast           (rlast),
        .rvalid          (rvalid),
        .rready          (rready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},   64'(done), 64'd1);
        check({tag, "_rready"}, 64'(rready), 64'd0);
        check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_tlast"},  64'(m_axis_tlast), 64'd0);
        check({tag, "_tdata"},  m_axis_tdata, 64'd0);
        check({tag, "_error"},  64'(error), 64'd0);
    endtask

    // One complete transfer of n beats.
    //   rv_pct   - rvalid probability, in percent
    //   tr_mode  - tready pattern: 0 = always 1, 1 = toggles every cycle, 2 = random
    //   bad_resp - source beat index that returns rresp=2 (-1 for none)
    //   bad_last - source beat index with rlast inverted (-1 for none)
    //   busy_at  - cycle at which start (size 5) is pulsed while busy (-1 for none)
    task automatic run_transfer(input int n, input int rv_pct, input int tr_mode,
                                input int bad_resp, input int bad_last, input int busy_at);
        int          e;
        int          sent;
        int          pushed;
        int          popped;
        int          cyc;
        int          last_acc;
        int          last_pop;
        int          done_edge;
        int          budget;
        int          rready_low;
        int          exp_done;
        logic [63:0] exp_data [$];
        logic        exp_last [$];
        logic [63:0] cur;
        logic [63:0] held_data;
        logic        held_last;
        logic        stall_prev;
        logic        exp_err;
        logic        exp_rr;

        e          = ((n + B - 1) / B) * B;
        sent       = 0;
        pushed     = 0;
        popped     = 0;
        cyc        = 0;
        last_acc   = 0;
        last_pop   = 0;
        done_edge  = -1;
        budget     = 30 * e + 100;
        rready_low = 0;
        stall_prev = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        exp_err    = (bad_resp >= 0) || (bad_last >= 0);
        cur        = rand64();

        @(negedge aclk);
        start           = 1'b1;
        dataSizeInBeats = 32'(n);
        rvalid          = 1'b0;
        @(posedge aclk);

        while (done_edge < 0 && cyc < budget) begin
            @(negedge aclk);
            if (done) begin
                done_edge = cyc;
            end else begin
                start           = (cyc == busy_at);
                dataSizeInBeats = (cyc == busy_at) ? 32'd5 : 32'(n);

                exp_rr = (sent < e) && ((pushed - popped) < 2);
                check("rready", 64'(rready), 64'(exp_rr));
                if (sent < e && !rready) rready_low++;

                if (stall_prev) begin
                    check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                    check("stall_tdata", m_axis_tdata, held_data);
                    check("stall_tlast", 64'(m_axis_tlast), 64'(held_last));
                end

                rvalid = (sent < e) && ($urandom_range(99) < 32'(rv_pct));
                rdata  = cur;
                rlast  = (((sent + 1) % B) == 0) != (sent == bad_last);
                rresp  = (sent == bad_resp) ? 2'd2 : 2'd0;
                case (tr_mode)
                    0:       m_axis_tready = 1'b1;
                    1:       m_axis_tready = (cyc % 2 == 0);
                    default: m_axis_tready = 1'($urandom_range(1));
                endcase

                if (m_axis_tvalid && m_axis_tready) begin
                    check("beat_expected", 64'(exp_data.size() > 0), 64'd1);
                    if (exp_data.size() > 0) begin
                        check("tdata", m_axis_tdata, exp_data.pop_front());
                        check("tlast", 64'(m_axis_tlast), 64'(exp_last.pop_front()));
                    end
                    popped++;
                    last_pop = cyc + 1;
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                held_data  = m_axis_tdata;
                held_last  = m_axis_tlast;

                if (rvalid && rready) begin
                    if (sent < n) begin
                        exp_data.push_back(cur);
                        exp_last.push_back(sent == n - 1);
                        pushed++;
                    end
                    sent++;
                    last_acc = cyc + 1;
                    cur      = rand64();
                end
                cyc++;
            end
        end
        rvalid = 1'b0;
        start  = 1'b0;

        check("done_reached", 64'(done_edge >= 0), 64'd1);
        check("beats_forwarded", 64'(popped), 64'(n));
        check("beats_accepted", 64'(sent), 64'(e));
        if (done_edge >= 0) begin
            exp_done = ((last_acc > last_pop) ? last_acc : last_pop) + 1;
            check("done_timing", 64'(done_edge), 64'(exp_done));
        end
        check("error", 64'(error), 64'(exp_err));
        if (tr_mode == 1) check("rready_dropped", 64'(rready_low > 0), 64'd1);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        dataSizeInBeats = '0;
        rid             = '0;
        rdata           = '0;
        rresp           = '0;
        rlast           = 1'b0;
        rvalid          = 1'b0;
        m_axis_tready   = 1'b0;

        repeat (3) @(negedge aclk);
        check_idle_outputs("reset_held");
        reset = 1'b0;
        @(negedge aclk);
        check_idle_outputs("reset_released");

        // Back-to-back full bursts.
        run_transfer(32, 100, 0, -1, -1, -1);
        // Surplus beats of the rounded-up final burst are dropped.
        run_transfer(20, 100, 0, -1, -1, -1);
        // Output stalls every other cycle.
        run_transfer(16, 100, 1, -1, -1, -1);
        // Bad response on beat 5 and a misplaced rlast on beat 8.
        run_transfer(16, 100, 0, 4, 7, -1);
        repeat (3) @(negedge aclk);
        check("error_sticky", 64'(error), 64'd1);

        // A zero-size start clears error and stays idle.
        @(negedge aclk);
        start           = 1'b1;
        dataSizeInBeats = 32'd0;
        @(negedge aclk);
        start  = 1'b0;
        rvalid = 1'b1;
        check("n0_error_cleared", 64'(error), 64'd0);
        repeat (3) begin
            @(negedge aclk);
            check("n0_done", 64'(done), 64'd1);
            check("n0_rready", 64'(rready), 64'd0);
            check("n0_tvalid", 64'(m_axis_tvalid), 64'd0);
        end
        rvalid = 1'b0;

        // A start pulsed mid-transfer must be ignored.
        run_transfer(32, 100, 0, -1, -1, 3);
        // Smallest transfer, done after one full burst.
        run_transfer(1, 100, 0, -1, -1, -1);

        // Asynchronous reset in the middle of a transfer.
        @(negedge aclk);
        start           = 1'b1;
        dataSizeInBeats = 32'd16;
        @(negedge aclk);
        start         = 1'b0;
        rvalid        = 1'b1;
        rdata         = rand64();
        m_axis_tready = 1'b1;
        repeat (7) @(posedge aclk);
        #2;
        check("pre_reset_busy", 64'(done), 64'd0);
        reset = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(negedge aclk);
        reset  = 1'b0;
        rvalid = 1'b0;
        run_transfer(16, 100, 0, -1, -1, -1);

        // Random sizes with random rvalid and random tready.
        for (int i = 0; i < 6; i++) begin
            run_transfer(int'($urandom_range(1, 40)), 60, 2, -1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/linear_read_data_sink.md
# linear_read_data_sink

Downstream companion of the linear AXI read address generator. Accepts the AXI4 read-data (R) channel beats produced in response to the fixed-length bursts the generator issues, and forwards exactly `dataSizeInBeats` beats onto an AXI-Stream master port, marking the final one with `m_axis_tlast`. Surplus beats from the rounded-up final burst are consumed and discarded. Response and burst-framing errors are flagged. Start/done handshake mirrors the address generator so both are launched by one controller with the same size.

## Interface
- `DATA_WIDTH`, 64, width of `rdata` / `m_axis_tdata` in bits
- `ID_WIDTH`, 8, width of `rid`; ignored apart from port width
- `SIZE_WIDTH`, 32, width of `dataSizeInBeats` and internal beat counters
- `AxLEN_BEATS_PER_TRANSFER`, 15, AXI burst length minus one; must match the address generator

- `aclk`  in  1  clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  launch a transfer; sampled only while `done`=1
- `done`  out  1  1 = idle / transfer complete
- `dataSizeInBeats`  in  SIZE_WIDTH  beats to forward, latched on accepted start
- `error`  out  1  sticky error flag, cleared by accepted start
- `rid`  in  ID_WIDTH  unused
- `rdata`  in  DATA_WIDTH  read data
- `rresp`  in  2  read response
- `rlast`  in  1  burst last beat
- `rvalid`  in  1  R valid
- `rready`  out  1  R ready
- `m_axis_tdata`  out  DATA_WIDTH  forwarded data
- `m_axis_tlast`  out  1  final forwarded beat
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tready`  in  1  stream ready

## Operation
- Reset values: `done`=1, `error`=0, `rready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0; state IDLE, counters 0, skid buffer empty. Reset mid-transfer abandons it; in-flight R beats are not the block's concern afterwards.
- Let B = AxLEN_BEATS_PER_TRANSFER+1. On `start && done`: N = `dataSizeInBeats`; E = ceil(N/B)*B computed at SIZE_WIDTH+1 bits (no overflow); received counter R=0, forwarded index F=0; `error`<=0; `done`<=0; go RUN. If N=0: `done` stays 1, `error` cleared, no beats accepted.
- `start` while `done`=0 is ignored.
- States: IDLE -> RUN (accepted start, N>0); RUN -> DRAIN (R beat accepted with R+1 = E); DRAIN -> IDLE (output buffer empty), `done`<=1 in that same edge.
- RUN: `rready`=1 whenever the 2-entry skid buffer has at least one free entry, else 0. `rready`=0 in IDLE and DRAIN.
- Per accepted beat (`rvalid && rready`): R<=R+1. If R < N, beat enters output buffer with tlast = (R = N-1). Else beat discarded.
- Framing check: `rlast` must equal ((R+1) mod B = 0). Mismatch or `rresp` != 0 sets `error`=1; beat still counted/forwarded normally.
- Output: head of buffer drives `m_axis_*`; pops on `m_axis_tvalid && m_axis_tready`. `m_axis_tdata`/`tlast` hold stable while valid and not ready.

## Timing
- R beat accepted at edge t appears on `m_axis_*` after edge t (1-cycle latency) when buffer was empty.
- Sustained 1 beat/cycle with `m_axis_tready` held 1. `rready` is registered from buffer occupancy; buffer never overflows (second entry absorbs a beat accepted while tready drops).
- Simultaneous push and pop: occupancy unchanged, order preserved.
- `done` rises the edge after the last tlast beat is popped, or the edge after the final surplus beat is accepted if the buffer is already empty. Earliest `done` for N=1, B=16, no stalls: 16 R beats plus 1 cycle.
- Counters never wrap: R stops at E, forwarding stops at N.

## Test plan
- N=32, B=16, 32 R beats back-to-back with rlast on beats 16/32, tready=1 -> 32 stream beats in order, tlast only on beat 32, `done` 1 cycle after, `error`=0.
- N=20 -> 32 R beats accepted, beats 21..32 dropped, exactly 20 forwarded, tlast on beat 20, `done` after 32nd accept.
- N=16, tready toggled 1/0 every cycle, rvalid always 1 -> no beat lost/duplicated, data stable during stalls, `rready` drops when buffer full.
- N=16, beat 5 with rresp=2 and rlast wrongly on beat 8 -> all 16 forwarded, `error`=1 sticky until next start, cleared on next start.
- start while busy, then N=0 start when idle -> first ignored; N=0 keeps `done`=1, `rready`=0.
- reset asserted mid-transfer (beat 7 of 16) -> outputs return to reset values immediately (async), `done`=1, new start works.
